// File: rtl/conv_job_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_job_arbiter_if
// Description : Engine-side bus of the convolution job arbiter: filter set,
//               start handshake, image read port and result write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_job_arbiter_if #(
    parameter int FIL_WIDTH      = 576,
    parameter int IMG_ADDR_WIDTH = 48,
    parameter int IMG_DATA_WIDTH = 128,
    parameter int RES_ADDR_WIDTH = 48,
    parameter int RES_DATA_WIDTH = 192,
    parameter int RES_WREN_WIDTH = 24
);
    logic [FIL_WIDTH-1:0]      eng_fil;
    logic                      eng_val_in;
    logic                      eng_rdy_in;
    logic [IMG_ADDR_WIDTH-1:0] eng_img_rdaddress;
    logic [IMG_DATA_WIDTH-1:0] eng_img_data_in;
    logic [RES_ADDR_WIDTH-1:0] eng_result_wraddress;
    logic [RES_DATA_WIDTH-1:0] eng_result_data_out;
    logic [RES_WREN_WIDTH-1:0] eng_result_wren;

    // Arbiter side: drives the filter, start request and read data.
    modport master (
        output eng_fil,
        output eng_val_in,
        output eng_img_data_in,
        input  eng_rdy_in,
        input  eng_img_rdaddress,
        input  eng_result_wraddress,
        input  eng_result_data_out,
        input  eng_result_wren
    );

    // Engine side.
    modport slave (
        input  eng_fil,
        input  eng_val_in,
        input  eng_img_data_in,
        output eng_rdy_in,
        output eng_img_rdaddress,
        output eng_result_wraddress,
        output eng_result_data_out,
        output eng_result_wren
    );
endinterface
`default_nettype wire

// File: rtl/conv_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : conv_job_arbiter
// Description : Round-robin sharing of one conv_reg_parallel engine between
//               NUM_REQ job sources. Captures the winner's filter set, runs
//               the engine start handshake, watches for completion (with a
//               watchdog) and routes image reads / result writes.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int FIL_WIDTH      = 576,
    parameter int IMG_ADDR_WIDTH = 48,
    parameter int IMG_DATA_WIDTH = 128,
    parameter int RES_ADDR_WIDTH = 48,
    parameter int RES_DATA_WIDTH = 192,
    parameter int RES_WREN_WIDTH = 24,
    parameter int MAX_CYCLES     = 1024
) (
    input  wire                                 clk,
    input  wire                                 reset,
    input  wire  [NUM_REQ-1:0]                  req_val,
    input  wire  [NUM_REQ*FIL_WIDTH-1:0]        req_fil,
    output logic [NUM_REQ-1:0]                  req_ack,
    output logic [NUM_REQ-1:0]                  req_done,
    output logic                                req_err,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [IMG_ADDR_WIDTH-1:0]           req_img_rdaddress,
    input  wire  [NUM_REQ*IMG_DATA_WIDTH-1:0]   req_img_data,
    output logic [RES_ADDR_WIDTH-1:0]           req_result_wraddress,
    output logic [RES_DATA_WIDTH-1:0]           req_result_data,
    output logic [NUM_REQ*RES_WREN_WIDTH-1:0]   req_result_wren,
    conv_job_arbiter_if.master                  eng
);
    localparam int REQ_IDX_WIDTH = $clog2(NUM_REQ);
    localparam int c_CNT_WIDTH   = $clog2(MAX_CYCLES + 1);
    localparam logic [c_CNT_WIDTH-1:0] c_CNT_LAST = c_CNT_WIDTH'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_timeout;
    logic [REQ_IDX_WIDTH-1:0]   r_ptr;
    logic [REQ_IDX_WIDTH-1:0]   r_idx;
    logic [NUM_REQ-1:0]         r_grant;
    logic [NUM_REQ-1:0]         r_ack;
    logic [FIL_WIDTH-1:0]       r_fil;
    logic [c_CNT_WIDTH-1:0]     r_cnt;
    logic                       r_seen_busy;
    logic                       r_err;
    logic                       w_win_found;
    logic [REQ_IDX_WIDTH-1:0]   w_win_idx;
    logic [REQ_IDX_WIDTH-1:0]   w_cand;

    // Round-robin search: first requester after the pointer, wrapping.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = REQ_IDX_WIDTH'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_win_found && req_val[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    // Next-state logic; completion takes priority over the watchdog.
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_found) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (eng.eng_rdy_in) begin
                    w_state_next = S_RUN;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_RUN: begin
                if (r_seen_busy && eng.eng_rdy_in) begin
                    w_state_next = S_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Grant capture, watchdog counter, busy tracking and pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= REQ_IDX_WIDTH'(NUM_REQ - 1);
            r_idx       <= '0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_fil       <= '0;
            r_cnt       <= '0;
            r_seen_busy <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    r_cnt       <= '0;
                    r_seen_busy <= 1'b0;
                    r_err       <= 1'b0;
                    if (w_win_found) begin
                        r_idx   <= w_win_idx;
                        r_grant <= NUM_REQ'(1) << w_win_idx;
                        r_ack   <= NUM_REQ'(1) << w_win_idx;
                        r_fil   <= req_fil[int'(w_win_idx)*FIL_WIDTH +: FIL_WIDTH];
                    end
                end
                S_ISSUE: begin
                    if (eng.eng_rdy_in) r_cnt <= '0;
                    else                r_cnt <= r_cnt + c_CNT_WIDTH'(1);
                end
                S_RUN: begin
                    r_cnt <= r_cnt + c_CNT_WIDTH'(1);
                    if (!eng.eng_rdy_in) r_seen_busy <= 1'b1;
                end
                S_DONE: begin
                    r_ptr   <= r_idx;
                    r_grant <= '0;
                end
                default: ;
            endcase
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign grant          = r_grant;
    assign req_ack        = r_ack;
    assign req_done       = (r_state == S_DONE) ? r_grant : '0;
    assign req_err        = (r_state == S_DONE) && r_err;
    assign eng.eng_fil    = r_fil;
    assign eng.eng_val_in = (r_state == S_ISSUE);

    assign req_img_rdaddress    = eng.eng_img_rdaddress;
    assign req_result_wraddress = eng.eng_result_wraddress;
    assign req_result_data      = eng.eng_result_data_out;
    assign eng.eng_img_data_in  = (|r_grant)
        ? req_img_data[int'(r_idx)*IMG_DATA_WIDTH +: IMG_DATA_WIDTH] : '0;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wren
            assign req_result_wren[gi*RES_WREN_WIDTH +: RES_WREN_WIDTH] =
                r_grant[gi] ? eng.eng_result_wren : '0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_conv_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_job_arbiter
// Description : Self-checking bench for conv_job_arbiter: reset state,
//               round-robin job table, routing, late handshake, watchdog
//               timeout and reset during a running job.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_job_arbiter;
    localparam int NR   = 4;
    localparam int FW   = 32;
    localparam int IAW  = 8;
    localparam int IDW  = 16;
    localparam int RAW  = 8;
    localparam int RDW  = 16;
    localparam int RWW  = 4;
    localparam int MAXC = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_val;
    logic [NR*FW-1:0]  req_fil;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     req_done;
    logic              req_err;
    logic [NR-1:0]     grant;
    logic [IAW-1:0]    req_img_rdaddress;
    logic [NR*IDW-1:0] req_img_data;
    logic [RAW-1:0]    req_result_wraddress;
    logic [RDW-1:0]    req_result_data;
    logic [NR*RWW-1:0] req_result_wren;

    int n_pass  = 0;
    int n_total = 0;
    int hs_count = 0;

    conv_job_arbiter_if #(
        .FIL_WIDTH(FW), .IMG_ADDR_WIDTH(IAW), .IMG_DATA_WIDTH(IDW),
        .RES_ADDR_WIDTH(RAW), .RES_DATA_WIDTH(RDW), .RES_WREN_WIDTH(RWW)
    ) eng_bus ();

    conv_job_arbiter #(
        .NUM_REQ(NR), .FIL_WIDTH(FW), .IMG_ADDR_WIDTH(IAW), .IMG_DATA_WIDTH(IDW),
        .RES_ADDR_WIDTH(RAW), .RES_DATA_WIDTH(RDW), .RES_WREN_WIDTH(RWW),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_val              (req_val),
        .req_fil              (req_fil),
        .req_ack              (req_ack),
        .req_done             (req_done),
        .req_err              (req_err),
        .grant                (grant),
        .req_img_rdaddress    (req_img_rdaddress),
        .req_img_data         (req_img_data),
        .req_result_wraddress (req_result_wraddress),
        .req_result_data      (req_result_data),
        .req_result_wren      (req_result_wren),
        .eng                  (eng_bus.master)
    );

    always #5 clk = ~clk;

    // Count accepted start handshakes.
    always @(posedge clk) begin
        if (!reset && eng_bus.eng_val_in && eng_bus.eng_rdy_in) hs_count++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [NR-1:0] val;
        int            busy;
        int            delay;
        logic [NR-1:0] exp_grant;
    } job_t;

    job_t jobs[8];

    function automatic logic [FW-1:0] fil_of(input int i);
        return 32'hA500_0000 | (32'(i) << 8) | 32'(i + 1);
    endfunction

    function automatic logic [IDW-1:0] img_of(input int i);
        return 16'h1100 * 16'(i + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load_fil();
        for (int i = 0; i < NR; i++) req_fil[i*FW +: FW] = fil_of(i);
    endtask

    task automatic run_job(input logic [NR-1:0] val, input int busy, input int delay,
                           input logic [NR-1:0] exp_g);
        int            g;
        int            hs0;
        logic          ok;
        logic [NR*RWW-1:0] exp_wren;
        g = 0;
        for (int i = 0; i < NR; i++) if (exp_g[i]) g = i;
        exp_wren = {{(NR*RWW-RWW){1'b0}}, {RWW{1'b1}}} << (RWW*g);
        load_fil();
        eng_bus.eng_rdy_in = 1'b1;
        req_val = val;
        tick();
        check("grant", 64'(grant), 64'(exp_g));
        check("ack", 64'(req_ack), 64'(exp_g));
        check("val_in_issue", 64'(eng_bus.eng_val_in), 64'd1);
        check("eng_fil", 64'(eng_bus.eng_fil), 64'(fil_of(g)));
        hs0 = hs_count;
        req_fil = ~req_fil;
        if (delay > 0) begin
            eng_bus.eng_rdy_in = 1'b0;
            ok = 1'b1;
            for (int k = 0; k < delay; k++) begin
                tick();
                if (!eng_bus.eng_val_in || req_ack != '0 || grant != exp_g) ok = 1'b0;
            end
            check("late_hold", 64'(ok), 64'd1);
            check("late_no_hs", 64'(hs_count - hs0), 64'd0);
            eng_bus.eng_rdy_in = 1'b1;
        end
        tick();
        eng_bus.eng_rdy_in = 1'b0;
        check("val_in_run", 64'(eng_bus.eng_val_in), 64'd0);
        check("hs_once", 64'(hs_count - hs0), 64'd1);
        ok = 1'b1;
        for (int k = 0; k < busy; k++) begin
            tick();
            if (eng_bus.eng_val_in || req_done != '0 || req_ack != '0 || grant != exp_g ||
                eng_bus.eng_fil != fil_of(g)) ok = 1'b0;
        end
        check("run_stable", 64'(ok), 64'd1);
        check("img_route", 64'(eng_bus.eng_img_data_in), 64'(img_of(g)));
        check("wren_route", 64'(req_result_wren), 64'(exp_wren));
        eng_bus.eng_rdy_in = 1'b1;
        tick();
        check("done", 64'(req_done), 64'(exp_g));
        check("err", 64'(req_err), 64'd0);
        check("hs_total", 64'(hs_count - hs0), 64'd1);
        tick();
        check("grant_idle", 64'(grant), 64'd0);
        check("done_clear", 64'(req_done), 64'd0);
    endtask

    initial begin
        logic ok;
        jobs[0] = '{4'b0001, 12, 0, 4'b0001};
        jobs[1] = '{4'b1111,  3, 0, 4'b0010};
        jobs[2] = '{4'b1111,  2, 5, 4'b0100};
        jobs[3] = '{4'b1111,  1, 0, 4'b1000};
        jobs[4] = '{4'b1111,  4, 0, 4'b0001};
        jobs[5] = '{4'b1111,  2, 0, 4'b0010};
        jobs[6] = '{4'b0101,  2, 0, 4'b0100};
        jobs[7] = '{4'b0011,  3, 0, 4'b0001};

        reset   = 1'b1;
        req_val = '0;
        load_fil();
        for (int i = 0; i < NR; i++) req_img_data[i*IDW +: IDW] = img_of(i);
        eng_bus.eng_rdy_in           = 1'b1;
        eng_bus.eng_img_rdaddress    = 8'h3C;
        eng_bus.eng_result_wraddress = 8'h5A;
        eng_bus.eng_result_data_out  = 16'hBEEF;
        eng_bus.eng_result_wren      = '1;
        tick();
        tick();
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ack", 64'(req_ack), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        check("rst_err", 64'(req_err), 64'd0);
        check("rst_val_in", 64'(eng_bus.eng_val_in), 64'd0);
        check("rst_fil", 64'(eng_bus.eng_fil), 64'd0);
        check("rst_img", 64'(eng_bus.eng_img_data_in), 64'd0);
        check("rst_wren", 64'(req_result_wren), 64'd0);
        check("bc_rdaddr", 64'(req_img_rdaddress), 64'h3C);
        check("bc_wraddr", 64'(req_result_wraddress), 64'h5A);
        check("bc_data", 64'(req_result_data), 64'hBEEF);
        reset = 1'b0;

        for (int j = 0; j < 8; j++)
            run_job(jobs[j].val, jobs[j].busy, jobs[j].delay, jobs[j].exp_grant);

        // Watchdog: engine never returns ready after the grant.
        load_fil();
        req_val = 4'b0001;
        tick();
        check("wd_grant", 64'(grant), 64'b0001);
        eng_bus.eng_rdy_in = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < MAXC - 1; k++) begin
            tick();
            if (req_done != '0 || !eng_bus.eng_val_in) ok = 1'b0;
        end
        check("wd_wait", 64'(ok), 64'd1);
        tick();
        check("wd_done", 64'(req_done), 64'b0001);
        check("wd_err", 64'(req_err), 64'd1);
        req_val = '0;
        tick();
        check("wd_idle_grant", 64'(grant), 64'd0);
        check("wd_idle_val", 64'(eng_bus.eng_val_in), 64'd0);
        check("wd_err_clear", 64'(req_err), 64'd0);

        // Reset in the middle of a running job.
        eng_bus.eng_rdy_in = 1'b1;
        req_val = 4'b1000;
        tick();
        check("rr_grant", 64'(grant), 64'b1000);
        tick();
        eng_bus.eng_rdy_in = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_val", 64'(eng_bus.eng_val_in), 64'd0);
        check("mid_rst_done", 64'(req_done), 64'd0);
        eng_bus.eng_rdy_in = 1'b1;
        tick();
        check("mid_rst_done2", 64'(req_done), 64'd0);
        reset   = 1'b0;
        req_val = 4'b0110;
        tick();
        check("post_rst_grant", 64'(grant), 64'b0010);
        check("post_rst_ack", 64'(req_ack), 64'b0010);
        check("post_rst_fil", 64'(eng_bus.eng_fil), 64'(fil_of(1)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
